// File: rtl/inst_fetch.sv
// Instruction fetch initiator: PC owner, 1-cycle memory pairing, one-entry skid buffer, redirect flush.
// Optional accepted-instruction counter enabled with `define IFU_PERF_CNT_EN.
module inst_fetch #(
    parameter int ADDR_W   = 3,
    parameter int INST_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       perf_cnt
);

    // state  | meaning
    // EMPTY  | nothing in flight, nothing buffered
    // STREAM | word in flight: memory returns it this cycle, tagged with pend_pc
    // HOLD   | stalled word parked in the skid buffer, no fetch in flight
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              pend;
    logic              skid_valid;
    logic              issue;

    assign pend       = (state == STREAM);
    assign skid_valid = (state == HOLD);
    assign mem_addr   = pc;

    always_comb begin
        out_inst = '0;
        out_pc   = pend_pc;
        if (skid_valid) begin
            out_inst = skid_inst;
            out_pc   = skid_pc;
        end else if (pend) begin
            out_inst = mem_inst;
            out_pc   = pend_pc;
        end
    end

    assign out_valid = (skid_valid || pend) && !redirect_valid;
    assign issue     = run && !redirect_valid && (out_ready || !out_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            pc        <= RST_PC;
            pend_pc   <= RST_PC;
            skid_pc   <= RST_PC;
            skid_inst <= '0;
        end else if (redirect_valid) begin
            state <= EMPTY;
            pc    <= redirect_pc;
        end else begin
            if (issue) begin
                pc      <= pc + ADDR_W'(1);
                pend_pc <= pc;
            end
            case (state)
                EMPTY: begin
                    if (issue) state <= STREAM;
                end
                STREAM: begin
                    // The memory word is only valid this cycle, so a stall must capture it now.
                    if (!out_ready) begin
                        state     <= HOLD;
                        skid_inst <= mem_inst;
                        skid_pc   <= pend_pc;
                    end else if (!issue) begin
                        state <= EMPTY;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= issue ? STREAM : EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic xfer;

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (xfer && (perf_cnt != 16'hFFFF)) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed stream/stall/redirect/run-drop/reset cases plus random traffic.
// Accepted words must follow consecutive PCs from the latest reset or redirect target.
module tb_inst_fetch;

    localparam int AW = 3;
    localparam int IW = 16;
`ifdef IFU_PERF_CNT_EN
    localparam int PERF_EN = 1;
`else
    localparam int PERF_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_inst = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [15:0]   perf_cnt;

    logic [IW-1:0] mem_tab [8] = '{16'h0000, 16'h0041, 16'h0082, 16'h00C3,
                                   16'h003F, 16'h007E, 16'h00BD, 16'h00FC};

    logic [AW+IW-1:0] exp_q [$];
    logic [AW+IW-1:0] mon_e;
    int n_cmp = 0;
    int n_fail = 0;
    int acc_cnt = 0;

    inst_fetch #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_cnt       (perf_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_inst <= mem_tab[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flush(input logic [AW-1:0] t);
        exp_q.delete();
        for (int i = 0; i < 2048; i++) begin
            logic [AW-1:0] p;
            p = t + AW'(i);
            exp_q.push_back({p, mem_tab[p]});
        end
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                flush('0);
                acc_cnt = 0;
                chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
            end else if (redirect_valid) begin
                flush(redirect_pc);
                chk("redirect_out_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_queue_empty", 32'd0, 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_out_pc", {29'd0, out_pc}, {29'd0, mon_e[AW+IW-1:IW]});
                    chk("sb_out_inst", {16'd0, out_inst}, {16'd0, mon_e[IW-1:0]});
                end
                acc_cnt++;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset state
        #1 rst_n = 1'b0;
        to_mid();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", {16'd0, out_inst}, 32'd0);
        chk("rst_pc", {29'd0, out_pc}, 32'd0);
        chk("rst_addr", {29'd0, mem_addr}, 32'd0);
        chk("rst_perf", {16'd0, perf_cnt}, 32'd0);
        to_next();

        // stream: first word visible after edge 1, then one word per cycle across the wrap
        rst_n = 1'b1;
        run = 1'b1;
        out_ready = 1'b1;
        to_mid();
        chk("stream_cycle0_valid", {31'd0, out_valid}, 32'd0);
        to_next();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) run = 1'b0;
            to_mid();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc", {29'd0, out_pc}, i % 8);
            chk("stream_inst", {16'd0, out_inst}, {16'd0, mem_tab[i % 8]});
            to_next();
        end
        to_mid();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);
        chk("stream_perf", {16'd0, perf_cnt}, (PERF_EN != 0) ? 32'd10 : 32'd0);
        chk("stream_addr", {29'd0, mem_addr}, 32'd2);
        to_next();

        // stall at pc 2 for three cycles
        run = 1'b1;
        to_mid();
        to_next();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_mid();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_pc", {29'd0, out_pc}, 32'd2);
            chk("stall_inst", {16'd0, out_inst}, 32'h0082);
            chk("stall_addr", {29'd0, mem_addr}, 32'd3);
            to_next();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                redirect_valid = 1'b1;
                redirect_pc = 3'd6;
            end
            to_mid();
            if (k < 7) begin
                chk("release_valid", {31'd0, out_valid}, 32'd1);
                chk("release_pc", {29'd0, out_pc}, (2 + k) % 8);
            end else begin
                chk("redir_bubble1", {31'd0, out_valid}, 32'd0);
            end
            to_next();
        end

        // redirect to 6: second bubble, then 6,7,0
        redirect_valid = 1'b0;
        to_mid();
        chk("redir_bubble2", {31'd0, out_valid}, 32'd0);
        to_next();
        for (int j = 0; j < 3; j++) begin
            to_mid();
            chk("redir_valid", {31'd0, out_valid}, 32'd1);
            chk("redir_pc", {29'd0, out_pc}, (6 + j) % 8);
            chk("redir_inst", {16'd0, out_inst}, {16'd0, mem_tab[(6 + j) % 8]});
            to_next();
        end

        // run drop with a word parked in the skid buffer
        out_ready = 1'b0;
        to_mid();
        chk("drop_pre_pc", {29'd0, out_pc}, 32'd1);
        to_next();
        run = 1'b0;
        out_ready = 1'b1;
        to_mid();
        chk("drop_skid_valid", {31'd0, out_valid}, 32'd1);
        chk("drop_skid_pc", {29'd0, out_pc}, 32'd1);
        chk("drop_skid_inst", {16'd0, out_inst}, 32'h0041);
        to_next();
        for (int k = 0; k < 2; k++) begin
            to_mid();
            chk("drop_empty_valid", {31'd0, out_valid}, 32'd0);
            chk("drop_addr_const", {29'd0, mem_addr}, 32'd2);
            to_next();
        end

        // asynchronous reset in the middle of a stream
        run = 1'b1;
        to_mid();
        to_next();
        to_mid();
        chk("prereset_pc", {29'd0, out_pc}, 32'd2);
        to_next();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_addr", {29'd0, mem_addr}, 32'd0);
        chk("async_rst_perf", {16'd0, perf_cnt}, 32'd0);
        to_next();
        rst_n = 1'b1;
        to_mid();
        chk("restart_cycle0", {31'd0, out_valid}, 32'd0);
        to_next();
        for (int j = 0; j < 2; j++) begin
            to_mid();
            chk("restart_valid", {31'd0, out_valid}, 32'd1);
            chk("restart_pc", {29'd0, out_pc}, j);
            to_next();
        end

        // random traffic against the scoreboard
        for (int c = 0; c < 1500; c++) begin
            run = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = AW'($urandom_range(0, 7));
            to_mid();
            to_next();
        end
        redirect_valid = 1'b0;
        run = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            to_mid();
            to_next();
        end
        to_mid();
        chk("final_empty", {31'd0, out_valid}, 32'd0);
        chk("final_perf", {16'd0, perf_cnt}, (PERF_EN != 0) ? acc_cnt : 32'd0);
        chk("random_progress", {31'd0, (acc_cnt > 200)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
